// File: rtl/calc_defs.sv
// Shared key-code definitions for the keypad scanner and the calculator
// control FSM that consumes its output.
//   KEY_W        : width of a key code
//   KEY_0..KEY_F : codes for the digit and hex keys
//   KEY_NONE     : code presented while no key is held
//   key_map()    : physical (row, col) position -> key code
package calc_defs;

  localparam int KEY_W = 5;

  typedef logic [KEY_W-1:0] key_t;

  localparam key_t KEY_0    = 5'h00;
  localparam key_t KEY_1    = 5'h01;
  localparam key_t KEY_2    = 5'h02;
  localparam key_t KEY_3    = 5'h03;
  localparam key_t KEY_4    = 5'h04;
  localparam key_t KEY_5    = 5'h05;
  localparam key_t KEY_6    = 5'h06;
  localparam key_t KEY_7    = 5'h07;
  localparam key_t KEY_8    = 5'h08;
  localparam key_t KEY_9    = 5'h09;
  localparam key_t KEY_A    = 5'h0A;
  localparam key_t KEY_B    = 5'h0B;
  localparam key_t KEY_C    = 5'h0C;
  localparam key_t KEY_D    = 5'h0D;
  localparam key_t KEY_E    = 5'h0E;
  localparam key_t KEY_F    = 5'h0F;
  localparam key_t KEY_NONE = 5'h10;

  // Keypad layout:
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: E 0 F D
  function automatic key_t key_map(input logic [1:0] row, input logic [1:0] col);
    key_t code;
    case ({row, col})
      4'h0:    code = KEY_1;
      4'h1:    code = KEY_2;
      4'h2:    code = KEY_3;
      4'h3:    code = KEY_A;
      4'h4:    code = KEY_4;
      4'h5:    code = KEY_5;
      4'h6:    code = KEY_6;
      4'h7:    code = KEY_B;
      4'h8:    code = KEY_7;
      4'h9:    code = KEY_8;
      4'hA:    code = KEY_9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_E;
      4'hD:    code = KEY_0;
      4'hE:    code = KEY_F;
      4'hF:    code = KEY_D;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the keypad scanner.
//   col_n     : column sense from the keypad, active-low, asynchronous
//   row_n     : row drive to the keypad, active-low, one row low at a time
//   key       : debounced key code (KEY_0..KEY_F or KEY_NONE)
//   key_press : one-cycle strobe on each newly accepted key
// master = the scanner; slave = keypad plus downstream consumer.
interface keypad_scanner_if;
  import calc_defs::*;

  logic [3:0] col_n;
  logic [3:0] row_n;
  key_t       key;
  logic       key_press;

  modport master (
    input  col_n,
    output row_n,
    output key,
    output key_press
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key,
    input  key_press
  );

endinterface

// File: rtl/key_debounce.sv
// Frame-level debouncer. Each frame_valid strobe delivers one complete scan
// result; the key code is only accepted after DEBOUNCE_CNT consecutive
// identical frames.
//   clk, rst    : clock, asynchronous active-high reset
//   frame_valid : one-cycle strobe at the end of every scan frame
//   frame_code  : that frame's resolved key code
//   key         : accepted (debounced) key code
//   key_press   : one-cycle pulse when key changes to a non-NONE code
module key_debounce #(
  parameter int DEBOUNCE_CNT = 3,
  parameter int KEY_W        = calc_defs::KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic [KEY_W-1:0] frame_code,
  output logic [KEY_W-1:0] key,
  output logic             key_press
);

  localparam int                 CNT_W     = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [KEY_W-1:0]   NONE_CODE = KEY_W'(calc_defs::KEY_NONE);

  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand       <= NONE_CODE;
      stable_cnt <= '0;
      key        <= NONE_CODE;
      key_press  <= 1'b0;
    end else begin
      key_press <= 1'b0;

      if (frame_valid) begin
        if (frame_code == cand) begin
          if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 1'b1;
        end else begin
          cand       <= frame_code;
          stable_cnt <= '0;
        end
      end

      // Acceptance looks at the registered (post-frame) counter, so key
      // moves one cycle after the frame that completed the debounce run.
      if (stable_cnt == CNT_MAX && cand != key) begin
        key       <= cand;
        key_press <= (cand != NONE_CODE);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Drives one row low at a time for SCAN_DIV
// cycles, samples the synchronised columns at the end of each dwell,
// resolves one key per 4-row frame (lowest row, then lowest column wins)
// and hands the frame result to the debouncer.
//   clk, rst : clock, asynchronous active-high reset
//   kp       : keypad_scanner_if master (col_n in; row_n, key, key_press out)
module keypad_scanner
  import calc_defs::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  keypad_scanner_if.master         kp
);

  localparam int               DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       col_p0;
  logic [3:0]       col_s;
  logic [DIV_W-1:0] dwell_cnt;
  logic [1:0]       row_idx;
  logic [1:0]       row_nxt;
  logic [3:0]       row_n_r;
  key_t             frame_code_r;

  logic             sample;
  logic             frame_start;
  logic             frame_valid;
  key_t             row_code;
  key_t             frame_res;
  key_t             key_o;
  logic             key_press_o;

  always_comb begin
    sample      = (dwell_cnt == DWELL_LAST);
    frame_start = (dwell_cnt == '0) && (row_idx == 2'd0);
    frame_valid = sample && (row_idx == 2'd3);
    row_nxt     = row_idx + 2'd1;

    // Scan columns high to low so the lowest low column ends up winning.
    row_code = KEY_NONE;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s[c]) row_code = key_map(row_idx, 2'(c));
    end

    // Row 3 is decoded in the same cycle the frame ends, so fold it in here.
    frame_res = (frame_code_r != KEY_NONE) ? frame_code_r : row_code;
  end

  // Stage: column synchroniser, dwell/row counters, frame accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_p0       <= 4'hF;
      col_s        <= 4'hF;
      dwell_cnt    <= '0;
      row_idx      <= 2'd0;
      row_n_r      <= 4'b1110;
      frame_code_r <= KEY_NONE;
    end else begin
      col_p0 <= kp.col_n;
      col_s  <= col_p0;

      if (sample) begin
        dwell_cnt <= '0;
        row_idx   <= row_nxt;
        row_n_r   <= ~(4'b0001 << row_nxt);
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end

      // Rows are visited in ascending order, so first-written wins gives
      // lowest-row priority across the frame.
      if (frame_start) begin
        frame_code_r <= KEY_NONE;
      end else if (sample && row_code != KEY_NONE && frame_code_r == KEY_NONE) begin
        frame_code_r <= row_code;
      end
    end
  end

  // Stage: frame-level debounce
  key_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .KEY_W        (KEY_W)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_code  (frame_res),
    .key         (key_o),
    .key_press   (key_press_o)
  );

  assign kp.row_n     = row_n_r;
  assign kp.key       = key_o;
  assign kp.key_press = key_press_o;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 (16-cycle frames).
// A keypad model turns a 16-bit "pressed" mask into col_n from the driven
// row. A frame-level reference model predicts row_n, key and key_press on
// every cycle; directed tests add literal checks on top.
module tb_keypad_scanner;
  import calc_defs::*;

  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV     (DIV),
    .DEBOUNCE_CNT (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp.master)
  );

  // Pressed-key mask, bit index = row*4 + col.
  logic [15:0] mask;
  logic [3:0]  cols;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.row_n[r] && mask[r*4+c]) cols[c] = 1'b0;
  end
  assign kp.col_n = cols;

  // Cycle index since reset release: k-th rising edge after reset.
  int k;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  int vectors     = 0;
  int miscompares = 0;
  int presses     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] tb_keymap(input int i);
    case (i)
      0: return 5'h01;  1: return 5'h02;  2: return 5'h03;  3: return 5'h0A;
      4: return 5'h04;  5: return 5'h05;  6: return 5'h06;  7: return 5'h0B;
      8: return 5'h07;  9: return 5'h08; 10: return 5'h09; 11: return 5'h0C;
     12: return 5'h0E; 13: return 5'h00; 14: return 5'h0F; 15: return 5'h0D;
      default: return 5'h10;
    endcase
  endfunction

  // Highest-priority held key: lowest row, then lowest column.
  function automatic logic [4:0] prio(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) return tb_keymap(i);
    return 5'h10;
  endfunction

  // Reference model: a frame's result is the priority key of the mask held
  // during that frame; key takes the value of the last DEB frame results
  // once they all agree, one cycle after the frame ends.
  logic [4:0] exp_key;
  logic       exp_press;
  logic [3:0] exp_row;
  logic [15:0] fm;
  logic [4:0] hist[$];
  logic       all_eq;

  always @(negedge clk) begin
    if (rst) begin
      exp_key = 5'h10;
      hist.delete();
      fm = '0;
      chk("rst_row_n", kp.row_n, 4'b1110);
      chk("rst_key", kp.key, 5'h10);
      chk("rst_key_press", kp.key_press, 1'b0);
    end else begin
      exp_press = 1'b0;
      if (k % FRAME == 1) begin
        if (k > 1) begin
          hist.push_back(prio(fm));
          if (hist.size() > DEB) void'(hist.pop_front());
          all_eq = (hist.size() == DEB);
          for (int i = 1; i < hist.size(); i++)
            if (hist[i] != hist[0]) all_eq = 1'b0;
          if (all_eq && hist[0] != exp_key) begin
            exp_press = (hist[0] != 5'h10);
            exp_key   = hist[0];
          end
        end
        fm = mask;
      end
      exp_row = ~(4'b0001 << ((k / DIV) % 4));
      chk("row_n", kp.row_n, exp_row);
      chk("key", kp.key, exp_key);
      chk("key_press", kp.key_press, exp_press);
      if (kp.key_press === 1'b1) presses++;
    end
  end

  task automatic to_boundary();
    do @(negedge clk); while (k % FRAME != 0);
  endtask

  task automatic frames(input int n);
    repeat (n) to_boundary();
  endtask

  initial begin
    logic [4:0] sweep_exp [16];
    sweep_exp = '{5'h01, 5'h02, 5'h03, 5'h0A, 5'h04, 5'h05, 5'h06, 5'h0B,
                  5'h07, 5'h08, 5'h09, 5'h0C, 5'h0E, 5'h00, 5'h0F, 5'h0D};

    mask = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);

    // 1: reset mid-frame while col_n = 4'b1101
    mask = 16'h2222;
    rst  = 1'b0;
    frames(1);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_row_n", kp.row_n, 4'b1110);
    chk("t1_async_key", kp.key, 5'h10);
    chk("t1_async_press", kp.key_press, 1'b0);
    mask = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    presses = 0;
    frames(3);
    chk("t1_idle_key", kp.key, 5'h10);
    chk("t1_idle_presses", presses, 0);

    // 2: clean press of "5"
    mask = 16'h0020;
    presses = 0;
    frames(4);
    chk("t2_key5", kp.key, 5'h05);
    chk("t2_presses", presses, 1);

    // 3: release
    mask = '0;
    presses = 0;
    frames(4);
    chk("t3_release", kp.key, 5'h10);
    chk("t3_presses", presses, 0);

    // 4: bounce on "9": present, present, absent, present, present, present
    mask = 16'h0400;
    presses = 0;
    frames(2);
    mask = '0;
    frames(1);
    mask = 16'h0400;
    frames(2);
    repeat (2) @(negedge clk);
    chk("t4_held_after_f5", kp.key, 5'h10);
    to_boundary();
    repeat (2) @(negedge clk);
    chk("t4_key9_after_f6", kp.key, 5'h09);
    chk("t4_presses", presses, 1);
    to_boundary();
    mask = '0;
    frames(4);
    chk("t4_release", kp.key, 5'h10);

    // 5: "A" and "7" together, then release "A"
    mask = 16'h0108;
    presses = 0;
    frames(4);
    chk("t5_multi_A", kp.key, 5'h0A);
    chk("t5_presses_A", presses, 1);
    mask = 16'h0100;
    presses = 0;
    frames(4);
    chk("t5_then_7", kp.key, 5'h07);
    chk("t5_presses_7", presses, 1);
    mask = '0;
    frames(4);

    // 6: key map sweep, each key held through a full debounce
    for (int i = 0; i < 16; i++) begin
      mask = 16'(1) << i;
      presses = 0;
      frames(4);
      chk($sformatf("t6_map_%0d", i), kp.key, sweep_exp[i]);
      chk($sformatf("t6_press_%0d", i), presses, 1);
    end
    mask = '0;
    frames(4);
    chk("t6_final_release", kp.key, 5'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
